// File: rtl/seven_segment_scan_decoder_if.sv
// Pin-side bundle of the seven-segment scan decoder: raw display drive in,
// recovered digits and frame status out.
interface seven_segment_scan_decoder_if #(
  parameter int DIGITS = 4
);
  logic [6:0]          seven_segment;
  logic [DIGITS-1:0]   digit_select;
  logic                capture_enable;
  logic [4*DIGITS-1:0] bcd_digits;
  logic [DIGITS-1:0]   bcd_valid;
  logic                frame_valid;
  logic                frame_strobe;
  logic                pattern_error;

  modport master (
    output seven_segment, digit_select, capture_enable,
    input  bcd_digits, bcd_valid, frame_valid, frame_strobe, pattern_error
  );

  modport slave (
    input  seven_segment, digit_select, capture_enable,
    output bcd_digits, bcd_valid, frame_valid, frame_strobe, pattern_error
  );
endinterface

// File: rtl/seven_segment_scan_decoder.sv
// Samples a multiplexed seven-segment display bus, waits for each digit's
// drive to settle, and recovers per-digit BCD values plus frame completion.
module seven_segment_scan_decoder #(
  parameter int DIGITS         = 4,
  parameter int STABLE_CYCLES  = 4,
  parameter bit ACTIVE_LOW_SEG = 1'b0,
  parameter bit ACTIVE_LOW_SEL = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  seven_segment_scan_decoder_if.slave  bus
);

  localparam int               CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  typedef struct packed {
    logic       legal;
    logic       blank;
    logic [3:0] value;
  } seg_decode_t;

  function automatic seg_decode_t decode_seg(input logic [6:0] seg);
    seg_decode_t d;
    d = '{legal: 1'b1, blank: 1'b0, value: 4'h0};
    case (seg)
      7'h3F: d.value = 4'd0;
      7'h06: d.value = 4'd1;
      7'h5B: d.value = 4'd2;
      7'h4F: d.value = 4'd3;
      7'h66: d.value = 4'd4;
      7'h6D: d.value = 4'd5;
      7'h7D: d.value = 4'd6;
      7'h07: d.value = 4'd7;
      7'h7F: d.value = 4'd8;
      7'h6F: d.value = 4'd9;
      7'h00:   d = '{legal: 1'b0, blank: 1'b1, value: 4'hF};
      default: d = '{legal: 1'b0, blank: 1'b0, value: 4'hE};
    endcase
    return d;
  endfunction

  // Input synchronizers and the previous-cycle copy used for change detection.
  logic [6:0]        seg_meta, seg_sync, seg_norm, seg_prev;
  logic [DIGITS-1:0] sel_meta, sel_sync, sel_norm, sel_prev;

  logic [CNT_W-1:0]    stable_cnt;
  logic                captured;
  logic [DIGITS-1:0]   seen_mask;

  logic [4*DIGITS-1:0] digits_q;
  logic [DIGITS-1:0]   valid_q;
  logic                frame_valid_q;
  logic                frame_strobe_q;
  logic                pattern_error_q;

  logic                hold_break;
  logic                capture;
  seg_decode_t         dec;
  logic [4*DIGITS-1:0] digits_next;
  logic [DIGITS-1:0]   valid_next;
  logic [DIGITS-1:0]   seen_next;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every flop sample the pre-edge
    // value, so the two synchronizer stages really are two cycles apart.
    if (rst) begin
      seg_meta <= '0;
      seg_sync <= '0;
      sel_meta <= '0;
      sel_sync <= '0;
      seg_prev <= '0;
      sel_prev <= '0;
    end else begin
      seg_meta <= bus.seven_segment;
      seg_sync <= seg_meta;
      sel_meta <= bus.digit_select;
      sel_sync <= sel_meta;
      seg_prev <= seg_norm;
      sel_prev <= sel_norm;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    seg_norm    = ACTIVE_LOW_SEG ? ~seg_sync : seg_sync;
    sel_norm    = ACTIVE_LOW_SEL ? ~sel_sync : sel_sync;
    digits_next = digits_q;
    valid_next  = valid_q;
    seen_next   = seen_mask;

    // Any scan transition, ghost (zero or multiple selects) or disable
    // restarts the settling window.
    hold_break = !bus.capture_enable || !$onehot(sel_norm) ||
                 (sel_norm != sel_prev) || (seg_norm != seg_prev);
    capture    = !hold_break && !captured && (stable_cnt == CNT_MAX);
    dec        = decode_seg(seg_norm);

    if (capture) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (sel_norm[i]) begin
          digits_next[4*i +: 4] = dec.value;
          valid_next[i]         = dec.legal;
          seen_next[i]          = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stable_cnt <= '0;
      captured   <= 1'b0;
    end else if (hold_break) begin
      stable_cnt <= '0;
      captured   <= 1'b0;
    end else begin
      if (stable_cnt != CNT_MAX) stable_cnt <= stable_cnt + 1'b1;
      if (capture)               captured   <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digits_q        <= {DIGITS{4'hF}};
      valid_q         <= '0;
      frame_valid_q   <= 1'b0;
      frame_strobe_q  <= 1'b0;
      pattern_error_q <= 1'b0;
      seen_mask       <= '0;
    end else begin
      frame_strobe_q  <= 1'b0;
      pattern_error_q <= 1'b0;
      if (capture) begin
        digits_q        <= digits_next;
        valid_q         <= valid_next;
        pattern_error_q <= !dec.legal && !dec.blank;
        // The capture that fills the mask closes the frame and starts the next.
        if (&seen_next) begin
          frame_strobe_q <= 1'b1;
          frame_valid_q  <= &valid_next;
          seen_mask      <= '0;
        end else begin
          seen_mask <= seen_next;
        end
      end else if (!bus.capture_enable) begin
        seen_mask <= '0;
      end
    end
  end

  assign bus.bcd_digits    = digits_q;
  assign bus.bcd_valid     = valid_q;
  assign bus.frame_valid   = frame_valid_q;
  assign bus.frame_strobe  = frame_strobe_q;
  assign bus.pattern_error = pattern_error_q;

endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// Bench for seven_segment_scan_decoder: directed scan scenarios plus random
// display traffic, all compared cycle by cycle against a behavioural model.
module tb_seven_segment_scan_decoder;

  localparam int DIGITS = 4;
  localparam int STABLE = 4;
  localparam logic [6:0] SEG_TBL [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seven_segment_scan_decoder_if #(.DIGITS(DIGITS)) dif ();

  seven_segment_scan_decoder #(
    .DIGITS(DIGITS), .STABLE_CYCLES(STABLE),
    .ACTIVE_LOW_SEG(1'b0), .ACTIVE_LOW_SEL(1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(dif)
  );

  int n_total = 0;
  int n_bad   = 0;
  int strobes = 0;
  int errs    = 0;

  // Reference model: pin samples per edge, length of the current settled run,
  // and the digit/frame state that the captures produce.
  logic [10:0] q[$];
  int          run;
  logic [3:0]  m_dig [DIGITS];
  logic [DIGITS-1:0] m_val, m_seen;
  logic        m_fv, m_strobe, m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] ref_decode(input logic [6:0] seg);
    for (int v = 0; v < 10; v++)
      if (SEG_TBL[v] == seg) return {1'b1, 4'(v)};
    return (seg == 7'h00) ? {1'b0, 4'hF} : {1'b0, 4'hE};
  endfunction

  function automatic logic [15:0] model_digits();
    logic [15:0] r;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = m_dig[i];
    return r;
  endfunction

  // q[0..2] = pins sampled three, two and one edges ago.
  function automatic bit edge_ok();
    return dif.capture_enable && (q[1] == q[0]) && $onehot(q[1][10:7]);
  endfunction

  function automatic bit capture_pending();
    return edge_ok() && (run == STABLE);
  endfunction

  task automatic model_edge();
    logic [10:0] cur;
    logic [4:0]  d;
    bit          ok;
    cur      = {dif.digit_select, dif.seven_segment};
    m_strobe = 1'b0;
    m_err    = 1'b0;
    if (rst) begin
      for (int i = 0; i < DIGITS; i++) m_dig[i] = 4'hF;
      m_val = '0; m_seen = '0; m_fv = 1'b0; run = 0;
      q.delete();
      repeat (3) q.push_back(11'h0);
      return;
    end
    ok = edge_ok();
    if (capture_pending()) begin
      d = ref_decode(q[1][6:0]);
      for (int i = 0; i < DIGITS; i++) begin
        if (q[1][7+i]) begin
          m_dig[i]  = d[3:0];
          m_val[i]  = d[4];
          m_seen[i] = 1'b1;
        end
      end
      m_err = !d[4] && (q[1][6:0] != 7'h00);
      if (&m_seen) begin
        m_strobe = 1'b1;
        m_fv     = &m_val;
        m_seen   = '0;
      end
    end
    run = ok ? run + 1 : 0;
    if (!dif.capture_enable) m_seen = '0;
    q.push_back(cur);
    void'(q.pop_front());
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    strobes += int'(dif.frame_strobe);
    errs    += int'(dif.pattern_error);
    check("cyc_digits", 32'(dif.bcd_digits), 32'(model_digits()));
    check("cyc_valid",  32'(dif.bcd_valid),  32'(m_val));
    check("cyc_fvalid", 32'(dif.frame_valid), 32'(m_fv));
    check("cyc_strobe", 32'(dif.frame_strobe), 32'(m_strobe));
    check("cyc_perr",   32'(dif.pattern_error), 32'(m_err));
  endtask

  task automatic drive(input logic [3:0] sel, input logic [6:0] seg, input int cycles);
    dif.digit_select  = sel;
    dif.seven_segment = seg;
    repeat (cycles) step();
  endtask

  initial begin
    bit hit;
    dif.seven_segment  = 7'h00;
    dif.digit_select   = '0;
    dif.capture_enable = 1'b0;
    rst = 1'b1;
    repeat (2) step();
    check("rst_digits", 32'(dif.bcd_digits), 32'h0000_FFFF);
    check("rst_valid",  32'(dif.bcd_valid), 32'h0);
    check("rst_fvalid", 32'(dif.frame_valid), 32'h0);
    rst = 1'b0;
    dif.capture_enable = 1'b1;

    // Full scan of 1,2,3,4
    strobes = 0;
    drive(4'b0001, 7'h06, 8);
    drive(4'b0010, 7'h5B, 8);
    drive(4'b0100, 7'h4F, 8);
    drive(4'b1000, 7'h66, 8);
    drive(4'b0000, 7'h00, 4);
    check("t1_digits",  32'(dif.bcd_digits), 32'h4321);
    check("t1_valid",   32'(dif.bcd_valid), 32'hF);
    check("t1_strobes", 32'(strobes), 32'd1);
    check("t1_fvalid",  32'(dif.frame_valid), 32'h1);

    // Too-short hold is filtered, then capture latency from first sample
    drive(4'b0001, 7'h3F, 3);
    drive(4'b0000, 7'h00, 10);
    check("t2_short", 32'(dif.bcd_digits[3:0]), 32'h1);
    dif.digit_select  = 4'b0001;
    dif.seven_segment = 7'h3F;
    for (int j = 0; j <= STABLE + 3; j++) begin
      step();
      check("t2_latency", 32'(dif.bcd_digits[3:0]), (j < STABLE + 3) ? 32'h1 : 32'h0);
    end
    drive(4'b0001, 7'h3F, 6);
    drive(4'b0000, 7'h00, 4);

    // Illegal pattern then blank on digit 2
    errs = 0;
    drive(4'b0100, 7'h49, 10);
    check("t3_err_dig",  32'(dif.bcd_digits[11:8]), 32'hE);
    check("t3_err_val",  32'(dif.bcd_valid[2]), 32'h0);
    check("t3_err_cnt",  32'(errs), 32'd1);
    errs = 0;
    drive(4'b0100, 7'h00, 10);
    check("t3_blank_dig", 32'(dif.bcd_digits[11:8]), 32'hF);
    check("t3_blank_err", 32'(errs), 32'd0);

    // Ghosting / no select
    strobes = 0;
    errs = 0;
    drive(4'b0011, 7'h06, 20);
    drive(4'b0000, 7'h06, 20);
    check("t4_strobes", 32'(strobes), 32'd0);
    check("t4_errs",    32'(errs), 32'd0);
    check("t4_digits",  32'(dif.bcd_digits), 32'h4F20);
    check("t4_valid",   32'(dif.bcd_valid), 32'b1011);

    // capture_enable drop discards a partial frame
    dif.capture_enable = 1'b0;
    drive(4'b0000, 7'h00, 3);
    dif.capture_enable = 1'b1;
    drive(4'b0000, 7'h00, 2);
    strobes = 0;
    drive(4'b0001, 7'h6D, 8);
    drive(4'b0010, 7'h7D, 8);
    dif.capture_enable = 1'b0;
    drive(4'b0000, 7'h00, 5);
    check("t5_hold", 32'(dif.bcd_digits[7:0]), 32'h65);
    dif.capture_enable = 1'b1;
    drive(4'b0000, 7'h00, 2);
    drive(4'b0100, 7'h07, 8);
    drive(4'b1000, 7'h7F, 8);
    check("t5_nostrobe", 32'(strobes), 32'd0);
    check("t5_mid_dig",  32'(dif.bcd_digits), 32'h8765);
    drive(4'b0001, 7'h6F, 8);
    drive(4'b0010, 7'h3F, 8);
    drive(4'b0000, 7'h00, 4);
    check("t5_strobes", 32'(strobes), 32'd1);
    check("t5_digits",  32'(dif.bcd_digits), 32'h8709);
    check("t5_fvalid",  32'(dif.frame_valid), 32'h1);

    // Reset collides with frame completion
    drive(4'b0001, 7'h06, 8);
    drive(4'b0010, 7'h06, 8);
    drive(4'b0100, 7'h06, 8);
    dif.digit_select  = 4'b1000;
    dif.seven_segment = 7'h06;
    hit = 1'b0;
    for (int j = 0; j < 30 && !hit; j++) begin
      if (capture_pending() && ((m_seen | 4'b1000) == 4'hF)) begin
        rst = 1'b1;
        hit = 1'b1;
      end
      step();
    end
    check("t6_trigger", 32'(hit), 32'h1);
    check("t6_strobe",  32'(dif.frame_strobe), 32'h0);
    check("t6_digits",  32'(dif.bcd_digits), 32'hFFFF);
    check("t6_valid",   32'(dif.bcd_valid), 32'h0);
    check("t6_fvalid",  32'(dif.frame_valid), 32'h0);
    rst = 1'b0;
    drive(4'b0000, 7'h00, 3);

    // Random display traffic
    for (int n = 0; n < 300; n++) begin
      logic [3:0] sel;
      logic [6:0] seg;
      int r;
      dif.capture_enable = ($urandom_range(0, 15) != 0);
      r   = $urandom_range(0, 9);
      sel = (r < 8) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
      r   = $urandom_range(0, 9);
      seg = (r < 6) ? SEG_TBL[$urandom_range(0, 9)] : (r < 8) ? 7'h00 : 7'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end
      drive(sel, seg, $urandom_range(1, 12));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
